// File: rtl/stfq_ranker.sv
// stfq_ranker: dual-channel STFQ rank computation and credit-gated push front end for the flow scheduler.
// Optional build macro STFQ_IDLE_RESET_EN: clears vt and all finish tags whenever the scheduler drains empty.
module stfq_ranker #(
  parameter int FLOWS = 10,
  parameter int DEPTH = 10,
  parameter int LEN_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arr_valid_1,
  input  logic                       arr_valid_2,
  output logic                       arr_ready_1,
  output logic                       arr_ready_2,
  input  logic [31:0]                arr_value_1,
  input  logic [31:0]                arr_value_2,
  input  logic [FLOWS-1:0]           arr_flow_1,
  input  logic [FLOWS-1:0]           arr_flow_2,
  input  logic [LEN_W-1:0]           arr_len_1,
  input  logic [LEN_W-1:0]           arr_len_2,
  input  logic                       cfg_we,
  input  logic [$clog2(FLOWS)-1:0]   cfg_flow,
  input  logic [3:0]                 cfg_shift,
  output logic                       push_1,
  output logic                       push_2,
  output logic [31:0]                push_rank_1,
  output logic [31:0]                push_rank_2,
  output logic [31:0]                push_value_1,
  output logic [31:0]                push_value_2,
  output logic [FLOWS-1:0]           push_flow_1,
  output logic [FLOWS-1:0]           push_flow_2,
  input  logic                       served_valid,
  input  logic [31:0]                served_rank,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       err_flow
);

  localparam int FW = $clog2(FLOWS);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0] finish    [FLOWS];
  logic [3:0]  shift_tab [FLOWS];
  logic [31:0] vt;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic one_hot(input logic [FLOWS-1:0] f);
    return (f != '0) && ((f & (f - FLOWS'(1))) == '0);
  endfunction

  function automatic logic [FW-1:0] encode(input logic [FLOWS-1:0] f);
    logic [FW-1:0] i;
    i = '0;
    for (int k = 0; k < FLOWS; k++)
      if (f[k]) i = FW'(k);
    return i;
  endfunction

  // A packet always costs at least one unit of virtual time.
  function automatic logic [31:0] cost(input logic [LEN_W-1:0] len, input logic [3:0] sh);
    logic [LEN_W-1:0] c;
    c = len >> sh;
    if (c == '0) c = LEN_W'(1);
    return 32'(c);
  endfunction

  logic          acc_1, acc_2, ok_1, ok_2, go_1, go_2, bad;
  logic [FW-1:0] idx_1, idx_2;
  logic [31:0]   start_1, start_2, fin_1, fin_2, base_2;
  logic [1:0]    n_push;
  logic [CW:0]   credits_sum;
  logic [CW-1:0] credits_next;

  assign arr_ready_1 = credits >= CW'(1);
  assign arr_ready_2 = credits >= CW'(2);

  assign acc_1 = arr_valid_1 & arr_ready_1;
  assign acc_2 = arr_valid_2 & arr_ready_2;
  assign ok_1  = one_hot(arr_flow_1);
  assign ok_2  = one_hot(arr_flow_2);
  assign go_1  = acc_1 & ok_1;
  assign go_2  = acc_2 & ok_2;
  assign bad   = (acc_1 & ~ok_1) | (acc_2 & ~ok_2);
  assign idx_1 = encode(arr_flow_1);
  assign idx_2 = encode(arr_flow_2);

  // Channel 2 chains off channel 1's fresh finish tag when both hit the same flow.
  always_comb begin
    start_1 = max32(vt, finish[idx_1]);
    fin_1   = sat_add(start_1, cost(arr_len_1, shift_tab[idx_1]));
    base_2  = (go_1 && (idx_1 == idx_2)) ? fin_1 : finish[idx_2];
    start_2 = max32(vt, base_2);
    fin_2   = sat_add(start_2, cost(arr_len_2, shift_tab[idx_2]));
  end

  // A served_valid at full credit is a protocol error; clamping absorbs it.
  always_comb begin
    n_push      = {1'b0, go_1} + {1'b0, go_2};
    credits_sum = {1'b0, credits} + (CW+1)'(served_valid) - (CW+1)'(n_push);
    if (credits_sum > DEPTH_W) credits_next = DEPTH_C;
    else                       credits_next = credits_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_1       <= 1'b0;
      push_2       <= 1'b0;
      push_rank_1  <= '0;
      push_rank_2  <= '0;
      push_value_1 <= '0;
      push_value_2 <= '0;
      push_flow_1  <= '0;
      push_flow_2  <= '0;
      credits      <= DEPTH_C;
      err_flow     <= 1'b0;
      vt           <= '0;
      for (int f = 0; f < FLOWS; f++) begin
        finish[f]    <= '0;
        shift_tab[f] <= '0;
      end
    end else begin
      credits <= credits_next;
      push_1  <= go_1 | go_2;
      push_2  <= go_1 & go_2;

      if (go_1) begin
        push_rank_1  <= start_1;
        push_value_1 <= arr_value_1;
        push_flow_1  <= arr_flow_1;
      end else if (go_2) begin
        push_rank_1  <= start_2;
        push_value_1 <= arr_value_2;
        push_flow_1  <= arr_flow_2;
      end

      if (go_1 && go_2) begin
        push_rank_2  <= start_2;
        push_value_2 <= arr_value_2;
        push_flow_2  <= arr_flow_2;
      end

      if (go_1) finish[idx_1] <= fin_1;
      if (go_2) finish[idx_2] <= fin_2;

      if (served_valid && (served_rank > vt)) vt <= served_rank;
      if (bad) err_flow <= 1'b1;

      if (cfg_we && ({1'b0, cfg_flow} < (FW+1)'(FLOWS)))
        shift_tab[cfg_flow] <= cfg_shift;

`ifdef STFQ_IDLE_RESET_EN
      if ((credits_next == DEPTH_C) && (n_push == 2'd0)) begin
        vt <= '0;
        for (int f = 0; f < FLOWS; f++) finish[f] <= '0;
      end
`else
`endif
    end
  end

endmodule

// File: tb/tb_stfq_ranker.sv
// tb_stfq_ranker: directed vector table plus randomized traffic checked against a tag-arithmetic model.
module tb_stfq_ranker;
  localparam int FLOWS = 10;
  localparam int DEPTH = 10;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             arr_valid_1, arr_valid_2, arr_ready_1, arr_ready_2;
  logic [31:0]      arr_value_1, arr_value_2;
  logic [FLOWS-1:0] arr_flow_1, arr_flow_2;
  logic [LEN_W-1:0] arr_len_1, arr_len_2;
  logic             cfg_we;
  logic [3:0]       cfg_flow;
  logic [3:0]       cfg_shift;
  logic             push_1, push_2;
  logic [31:0]      push_rank_1, push_rank_2, push_value_1, push_value_2;
  logic [FLOWS-1:0] push_flow_1, push_flow_2;
  logic             served_valid;
  logic [31:0]      served_rank;
  logic [3:0]       credits;
  logic             err_flow;

  always #5 clk = ~clk;

  stfq_ranker #(.FLOWS(FLOWS), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .arr_valid_1(arr_valid_1), .arr_valid_2(arr_valid_2),
    .arr_ready_1(arr_ready_1), .arr_ready_2(arr_ready_2),
    .arr_value_1(arr_value_1), .arr_value_2(arr_value_2),
    .arr_flow_1(arr_flow_1), .arr_flow_2(arr_flow_2),
    .arr_len_1(arr_len_1), .arr_len_2(arr_len_2),
    .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_shift(cfg_shift),
    .push_1(push_1), .push_2(push_2),
    .push_rank_1(push_rank_1), .push_rank_2(push_rank_2),
    .push_value_1(push_value_1), .push_value_2(push_value_2),
    .push_flow_1(push_flow_1), .push_flow_2(push_flow_2),
    .served_valid(served_valid), .served_rank(served_rank),
    .credits(credits), .err_flow(err_flow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic rst, v1, v2, sv, cw;
    logic [FLOWS-1:0] f1, f2;
    logic [LEN_W-1:0] l1, l2;
    logic [31:0] sr;
    logic [3:0] cf, cs;
    logic r1, r2, p1, p2;
    logic [31:0] k1, k2;
    logic [FLOWS-1:0] pf1;
    int cred;
    logic err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rs, int v1, int f1, int l1, int v2, int f2, int l2,
                              int sv, int unsigned sr, int cw, int cf, int cs,
                              int r1, int r2, int p1, int p2, int unsigned k1, int unsigned k2,
                              int pf1, int cred, int err);
    vec_t v;
    v.rst = rs[0]; v.v1 = v1[0]; v.f1 = FLOWS'(f1); v.l1 = LEN_W'(l1);
    v.v2 = v2[0]; v.f2 = FLOWS'(f2); v.l2 = LEN_W'(l2);
    v.sv = sv[0]; v.sr = sr; v.cw = cw[0]; v.cf = 4'(cf); v.cs = 4'(cs);
    v.r1 = r1[0]; v.r2 = r2[0]; v.p1 = p1[0]; v.p2 = p2[0];
    v.k1 = k1; v.k2 = k2; v.pf1 = FLOWS'(pf1); v.cred = cred; v.err = err[0];
    return v;
  endfunction

  task automatic idle_inputs();
    arr_valid_1 = 0; arr_valid_2 = 0; arr_value_1 = '0; arr_value_2 = '0;
    arr_flow_1 = '0; arr_flow_2 = '0; arr_len_1 = '0; arr_len_2 = '0;
    cfg_we = 0; cfg_flow = '0; cfg_shift = '0; served_valid = 0; served_rank = '0;
  endtask

  task automatic apply(input vec_t v, input int i);
    rst = v.rst;
    arr_valid_1 = v.v1; arr_flow_1 = v.f1; arr_len_1 = v.l1; arr_value_1 = 32'hA000_0000 + 32'(i);
    arr_valid_2 = v.v2; arr_flow_2 = v.f2; arr_len_2 = v.l2; arr_value_2 = 32'hB000_0000 + 32'(i);
    served_valid = v.sv; served_rank = v.sr;
    cfg_we = v.cw; cfg_flow = v.cf; cfg_shift = v.cs;
    #1;
    check($sformatf("vec%0d ready_1", i), 32'(arr_ready_1), 32'(v.r1));
    check($sformatf("vec%0d ready_2", i), 32'(arr_ready_2), 32'(v.r2));
    @(posedge clk); #1;
    check($sformatf("vec%0d push_1", i), 32'(push_1), 32'(v.p1));
    check($sformatf("vec%0d push_2", i), 32'(push_2), 32'(v.p2));
    if (v.p1) begin
      check($sformatf("vec%0d rank_1", i), push_rank_1, v.k1);
      check($sformatf("vec%0d flow_1", i), 32'(push_flow_1), 32'(v.pf1));
    end
    if (v.p2) check($sformatf("vec%0d rank_2", i), push_rank_2, v.k2);
    check($sformatf("vec%0d credits", i), 32'(credits), 32'(v.cred));
    check($sformatf("vec%0d err_flow", i), 32'(err_flow), 32'(v.err));
  endtask

  // Reference model: tags kept per flow, credits as a plain count.
  logic [31:0] mfin [FLOWS];
  int          mshf [FLOWS];
  logic [31:0] mvt;
  int          mcred;
  logic        merr;
  int          exp_n;
  logic [31:0] exp_rank [2];
  logic [31:0] exp_val [2];
  logic [FLOWS-1:0] exp_flow [2];

  task automatic model_reset();
    for (int f = 0; f < FLOWS; f++) begin mfin[f] = '0; mshf[f] = 0; end
    mvt = '0; mcred = DEPTH; merr = 0; exp_n = 0;
  endtask

  task automatic model_step();
    logic [FLOWS-1:0] fl [2];
    logic [LEN_W-1:0] ln [2];
    logic [31:0] vl [2];
    logic take [2];
    logic [31:0] c, s;
    logic [63:0] sum;
    int idx, n, newc;
    fl[0] = arr_flow_1; fl[1] = arr_flow_2;
    ln[0] = arr_len_1;  ln[1] = arr_len_2;
    vl[0] = arr_value_1; vl[1] = arr_value_2;
    take[0] = arr_valid_1 && (mcred >= 1);
    take[1] = arr_valid_2 && (mcred >= 2);
    n = 0;
    for (int ch = 0; ch < 2; ch++) begin
      if (take[ch]) begin
        if ($countones(fl[ch]) == 1) begin
          idx = 0;
          for (int k = 0; k < FLOWS; k++) if (fl[ch][k]) idx = k;
          c = 32'(ln[ch]) >> mshf[idx];
          if (c == 0) c = 1;
          s = (mvt > mfin[idx]) ? mvt : mfin[idx];
          sum = 64'(s) + 64'(c);
          mfin[idx] = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
          exp_rank[n] = s; exp_val[n] = vl[ch]; exp_flow[n] = fl[ch];
          n++;
        end else merr = 1;
      end
    end
    exp_n = n;
    newc = mcred - n + (served_valid ? 1 : 0);
    if (newc > DEPTH) newc = DEPTH;
    if (served_valid && served_rank > mvt) mvt = served_rank;
    if (cfg_we && int'(cfg_flow) < FLOWS) mshf[int'(cfg_flow)] = int'(cfg_shift);
`ifdef STFQ_IDLE_RESET_EN
    if (newc == DEPTH && n == 0) begin
      mvt = '0;
      for (int f = 0; f < FLOWS; f++) mfin[f] = '0;
    end
`endif
    mcred = newc;
  endtask

  function automatic logic [FLOWS-1:0] rand_flow();
    logic [FLOWS-1:0] f;
    int r, a, b;
    f = '0;
    r = $urandom_range(0, 15);
    if (r == 0) f = '0;
    else if (r == 1) begin
      a = $urandom_range(0, FLOWS-1);
      b = (a + 1 + $urandom_range(0, FLOWS-2)) % FLOWS;
      f[a] = 1'b1; f[b] = 1'b1;
    end else if (r < 9) f[$urandom_range(0, 3)] = 1'b1;
    else f[$urandom_range(0, FLOWS-1)] = 1'b1;
    return f;
  endfunction

  function automatic logic [LEN_W-1:0] rand_len();
    if ($urandom_range(0, 7) == 0) return LEN_W'($urandom_range(0, 65535));
    return LEN_W'($urandom_range(0, 199));
  endfunction

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset push_1", 32'(push_1), 0);
    check("reset push_2", 32'(push_2), 0);
    check("reset rank_1", push_rank_1, 0);
    check("reset value_2", push_value_2, 0);
    check("reset credits", 32'(credits), DEPTH);
    check("reset ready_1", 32'(arr_ready_1), 1);
    check("reset ready_2", 32'(arr_ready_2), 1);
    check("reset err_flow", 32'(err_flow), 0);

    // Arrivals held under reset must not be accepted.
    arr_valid_1 = 1; arr_flow_1 = 10'h001; arr_len_1 = 16'd5;
    repeat (2) begin
      @(posedge clk); #1;
      check("held rst push_1", 32'(push_1), 0);
      check("held rst credits", 32'(credits), DEPTH);
    end
    idle_inputs();

    //               rs v1 f1     l1  v2 f2     l2 sv sr            cw cf cs  r1 r2 p1 p2 k1            k2  pf1    cr er
    tbl.push_back(mk(0, 1,'h001,100, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 0,            0,  'h001, 9, 0));
    tbl.push_back(mk(0, 1,'h001,100, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 100,          0,  'h001, 8, 0));
    tbl.push_back(mk(0, 1,'h001,100, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 200,          0,  'h001, 7, 0));
    tbl.push_back(mk(1, 0,0,       0, 0,0,     0, 0,0,            0,0,0,   1,1, 0,0, 0,            0,  0,    10, 0));
    tbl.push_back(mk(0, 1,'h001, 40, 1,'h001, 60, 0,0,            0,0,0,   1,1, 1,1, 0,            40, 'h001, 8, 0));
    tbl.push_back(mk(0, 1,'h001,  1, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 100,          0,  'h001, 7, 0));
    tbl.push_back(mk(0, 0,0,       0, 0,0,     0, 0,0,            1,1,2,   1,1, 0,0, 0,            0,  0,     7, 0));
    tbl.push_back(mk(0, 1,'h002, 64, 1,'h004, 64, 0,0,            0,0,0,   1,1, 1,1, 0,            0,  'h002, 5, 0));
    tbl.push_back(mk(0, 1,'h002, 64, 1,'h004,  1, 0,0,            0,0,0,   1,1, 1,1, 16,           64, 'h002, 3, 0));
    tbl.push_back(mk(0, 1,0,       5, 1,'h008,  5, 0,0,            0,0,0,   1,1, 1,0, 0,            0,  'h008, 2, 1));
    tbl.push_back(mk(0, 1,'h003,  5, 0,0,     0, 0,0,            0,0,0,   1,1, 0,0, 0,            0,  0,     2, 1));
    tbl.push_back(mk(0, 1,'h010, 10, 0,0,     0, 1,500,          0,0,0,   1,1, 1,0, 0,            0,  'h010, 2, 1));
    tbl.push_back(mk(0, 1,'h020,  1, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 500,          0,  'h020, 1, 1));
    tbl.push_back(mk(0, 1,'h040,  1, 1,'h040,  1, 0,0,            0,0,0,   1,0, 1,0, 500,          0,  'h040, 0, 1));
    tbl.push_back(mk(0, 1,'h040,  1, 1,'h040,  1, 0,0,            0,0,0,   0,0, 0,0, 0,            0,  0,     0, 1));
    tbl.push_back(mk(0, 0,0,       0, 0,0,     0, 1,100,          0,0,0,   0,0, 0,0, 0,            0,  0,     1, 1));
    tbl.push_back(mk(0, 0,0,       0, 0,0,     0, 1,0,            0,0,0,   1,0, 0,0, 0,            0,  0,     2, 1));
    tbl.push_back(mk(0, 1,'h040,  1, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 501,          0,  'h040, 1, 1));
    tbl.push_back(mk(0, 1,'h001,  1, 0,0,     0, 0,0,            0,0,0,   1,0, 1,0, 500,          0,  'h001, 0, 1));
    tbl.push_back(mk(1, 0,0,       0, 0,0,     0, 0,0,            0,0,0,   0,0, 0,0, 0,            0,  0,    10, 0));
    tbl.push_back(mk(0, 1,'h001,  7, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 0,            0,  'h001, 9, 0));
    tbl.push_back(mk(0, 1,'h080,  1, 0,0,     0, 1,'hFFFF_FFF0,  0,0,0,   1,1, 1,0, 0,            0,  'h080, 9, 0));
    tbl.push_back(mk(0, 1,'h080,100, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 'hFFFF_FFF0,  0,  'h080, 8, 0));
    tbl.push_back(mk(0, 1,'h080,  1, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 'hFFFF_FFFF,  0,  'h080, 7, 0));
    tbl.push_back(mk(0, 1,'h100,  8, 0,0,     0, 0,0,            1,8,3,   1,1, 1,0, 'hFFFF_FFF0,  0,  'h100, 6, 0));
    tbl.push_back(mk(0, 1,'h100,  8, 0,0,     0, 0,0,            0,0,0,   1,1, 1,0, 'hFFFF_FFF8,  0,  'h100, 5, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Randomized traffic against the model.
    rst = 1; idle_inputs();
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      arr_valid_1 = ($urandom_range(0, 3) != 0);
      arr_valid_2 = ($urandom_range(0, 2) != 0);
      arr_flow_1 = rand_flow(); arr_flow_2 = rand_flow();
      arr_len_1 = rand_len();   arr_len_2 = rand_len();
      arr_value_1 = $urandom(); arr_value_2 = $urandom();
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_flow = 4'($urandom_range(0, 15));
      cfg_shift = 4'($urandom_range(0, 15));
      served_valid = (mcred < DEPTH) && ($urandom_range(0, 2) == 0);
      served_rank = ($urandom_range(0, 1) == 0) ? mvt + 32'($urandom_range(0, 400))
                                                 : 32'($urandom_range(0, 1000));
      #1;
      check("rnd ready_1", 32'(arr_ready_1), 32'(mcred >= 1));
      check("rnd ready_2", 32'(arr_ready_2), 32'(mcred >= 2));
      model_step();
      @(posedge clk); #1;
      check("rnd push_1", 32'(push_1), 32'(exp_n >= 1));
      check("rnd push_2", 32'(push_2), 32'(exp_n >= 2));
      if (exp_n >= 1) begin
        check("rnd rank_1", push_rank_1, exp_rank[0]);
        check("rnd value_1", push_value_1, exp_val[0]);
        check("rnd flow_1", 32'(push_flow_1), 32'(exp_flow[0]));
      end
      if (exp_n >= 2) begin
        check("rnd rank_2", push_rank_2, exp_rank[1]);
        check("rnd value_2", push_value_2, exp_val[1]);
        check("rnd flow_2", 32'(push_flow_2), 32'(exp_flow[1]));
      end
      check("rnd credits", 32'(credits), 32'(mcred));
      check("rnd err_flow", 32'(err_flow), 32'(merr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
